// File: rtl/wm_pixel_sequencer.sv
// Watermark pixel sequencer: walks an image in raster order, fetches pixels from
// a shared memory, routes pixels inside the watermark window through the blend unit.
module wm_pixel_sequencer #(
  parameter int unsigned Data_Depth      = 8,
  parameter int unsigned amba_word       = 16,
  parameter int unsigned amba_addr_depth = 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       PSEL,
  input  logic                       PENABLE,
  input  logic                       PWRITE,
  input  logic [amba_addr_depth-1:0] PADDR,
  input  logic [amba_word-1:0]       PWDATA,
  output logic [amba_word-1:0]       PRDATA,
  output logic                       mem_rd,
  output logic [16:0]                mem_addr,
  input  logic [Data_Depth-1:0]      mem_rdata,
  output logic                       blend_go,
  output logic [Data_Depth-1:0]      blend_img,
  output logic [Data_Depth-1:0]      blend_wm,
  input  logic                       blend_done,
  input  logic [Data_Depth-1:0]      blend_res,
  output logic [Data_Depth-1:0]      Pixel_Data,
  output logic                       new_pixel,
  output logic                       Image_Done
);

  localparam int unsigned DimW = 8;
  localparam int unsigned CntW = 16;
  localparam int unsigned MaW  = 17;

  typedef enum logic [2:0] {
    IDLE, REQ_IMG, WAIT_IMG, REQ_WM, WAIT_WM, BLEND, EMIT, DONE
  } state_e;

  state_e state_q, state_d;

  logic [DimW-1:0] img_rows_q, img_rows_d, img_cols_q, img_cols_d;
  logic [DimW-1:0] wm_rows_q, wm_rows_d, wm_cols_q, wm_cols_d;
  logic [DimW-1:0] wm_row_q, wm_row_d, wm_col_q, wm_col_d;
  logic [DimW-1:0] r_q, r_d, c_q, c_d;
  logic [CntW-1:0] img_idx_q, img_idx_d, wm_idx_q, wm_idx_d;
  logic [CntW-1:0] pix_cnt_q, pix_cnt_d;
  logic            done_sticky_q, done_sticky_d;

  logic [amba_word-1:0]  prdata_q, prdata_d;
  logic                  mem_rd_q, mem_rd_d;
  logic [MaW-1:0]        mem_addr_q, mem_addr_d;
  logic                  blend_go_q, blend_go_d;
  logic [Data_Depth-1:0] blend_img_q, blend_img_d, blend_wm_q, blend_wm_d;
  logic [Data_Depth-1:0] pixel_data_q, pixel_data_d;
  logic                  new_pixel_q, new_pixel_d;
  logic                  image_done_q, image_done_d;

  logic                 wr_en, rd_en, ctrl_wr, start_req, abort_req, busy;
  logic [amba_word-1:0] rd_word;
  logic [DimW:0]        win_row_end, win_col_end, wm_step;
  logic                 row_in, col_in, in_win, last_col, last_row;

  assign wr_en     = PSEL & PENABLE & PWRITE;
  assign rd_en     = PSEL & ~PENABLE & ~PWRITE;
  assign ctrl_wr   = wr_en && (PADDR == amba_addr_depth'(0));
  assign start_req = ctrl_wr && PWDATA[0];
  assign abort_req = ctrl_wr && PWDATA[1];
  assign busy      = (state_q != IDLE);

  // Window bounds kept 9 bits wide so a window reaching past 255 does not wrap.
  assign win_row_end = {1'b0, wm_row_q} + {1'b0, wm_rows_q};
  assign win_col_end = {1'b0, wm_col_q} + {1'b0, wm_cols_q};
  assign row_in      = ({1'b0, r_q} >= {1'b0, wm_row_q}) && ({1'b0, r_q} < win_row_end);
  assign col_in      = ({1'b0, c_q} >= {1'b0, wm_col_q}) && ({1'b0, c_q} < win_col_end);
  assign in_win      = row_in && col_in;
  assign last_col    = (c_q == (img_cols_q - 8'd1));
  assign last_row    = (r_q == (img_rows_q - 8'd1));
  // At the right image edge, skip the clipped tail of the watermark row.
  assign wm_step     = last_col ? (win_col_end - {1'b0, c_q}) : 9'd1;

  always_comb begin
    rd_word = '0;
    case (PADDR)
      amba_addr_depth'(1): rd_word = amba_word'({img_rows_q, img_cols_q});
      amba_addr_depth'(2): rd_word = amba_word'({wm_rows_q, wm_cols_q});
      amba_addr_depth'(3): rd_word = amba_word'({wm_row_q, wm_col_q});
      amba_addr_depth'(4): rd_word = amba_word'({done_sticky_q, busy});
      amba_addr_depth'(5): rd_word = amba_word'(pix_cnt_q);
      default:             rd_word = '0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    img_rows_d    = img_rows_q;
    img_cols_d    = img_cols_q;
    wm_rows_d     = wm_rows_q;
    wm_cols_d     = wm_cols_q;
    wm_row_d      = wm_row_q;
    wm_col_d      = wm_col_q;
    r_d           = r_q;
    c_d           = c_q;
    img_idx_d     = img_idx_q;
    wm_idx_d      = wm_idx_q;
    pix_cnt_d     = pix_cnt_q;
    done_sticky_d = done_sticky_q;
    prdata_d      = prdata_q;
    blend_img_d   = blend_img_q;
    blend_wm_d    = blend_wm_q;
    pixel_data_d  = pixel_data_q;
    mem_rd_d      = 1'b0;
    mem_addr_d    = '0;
    blend_go_d    = 1'b0;
    new_pixel_d   = 1'b0;
    image_done_d  = 1'b0;

    if (rd_en) prdata_d = rd_word;

    if (wr_en && !busy) begin
      case (PADDR)
        amba_addr_depth'(1): begin img_rows_d = PWDATA[15:8]; img_cols_d = PWDATA[7:0]; end
        amba_addr_depth'(2): begin wm_rows_d  = PWDATA[15:8]; wm_cols_d  = PWDATA[7:0]; end
        amba_addr_depth'(3): begin wm_row_d   = PWDATA[15:8]; wm_col_d   = PWDATA[7:0]; end
        default: ;
      endcase
    end

    case (state_q)
      IDLE: begin
        if (start_req && !abort_req) begin
          r_d           = '0;
          c_d           = '0;
          img_idx_d     = '0;
          wm_idx_d      = '0;
          pix_cnt_d     = '0;
          done_sticky_d = 1'b0;
          state_d       = ((img_rows_q == '0) || (img_cols_q == '0)) ? DONE : REQ_IMG;
        end
      end
      REQ_IMG: state_d = WAIT_IMG;
      WAIT_IMG: begin
        if (in_win) begin
          blend_img_d = mem_rdata;
          state_d     = REQ_WM;
        end else begin
          pixel_data_d = mem_rdata;
          state_d      = EMIT;
        end
      end
      REQ_WM: state_d = WAIT_WM;
      WAIT_WM: begin
        blend_wm_d = mem_rdata;
        state_d    = BLEND;
      end
      BLEND: begin
        if (blend_done) begin
          pixel_data_d = blend_res;
          state_d      = EMIT;
        end
      end
      EMIT: begin
        pix_cnt_d = pix_cnt_q + 16'd1;
        img_idx_d = img_idx_q + 16'd1;
        if (in_win) wm_idx_d = wm_idx_q + 16'(wm_step);
        if (last_col) begin
          c_d = '0;
          r_d = r_q + 8'd1;
        end else begin
          c_d = c_q + 8'd1;
        end
        state_d = (last_col && last_row) ? DONE : REQ_IMG;
      end
      DONE: begin
        done_sticky_d = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (abort_req) state_d = IDLE;

    // Outputs are registered from the next state so they line up with it.
    mem_rd_d     = (state_d == REQ_IMG) || (state_d == REQ_WM);
    if (state_d == REQ_IMG) mem_addr_d = {1'b0, img_idx_d};
    if (state_d == REQ_WM)  mem_addr_d = {1'b1, wm_idx_d};
    blend_go_d   = (state_d == BLEND) && (state_q != BLEND);
    new_pixel_d  = (state_d == EMIT);
    image_done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      img_rows_q    <= '0;
      img_cols_q    <= '0;
      wm_rows_q     <= '0;
      wm_cols_q     <= '0;
      wm_row_q      <= '0;
      wm_col_q      <= '0;
      r_q           <= '0;
      c_q           <= '0;
      img_idx_q     <= '0;
      wm_idx_q      <= '0;
      pix_cnt_q     <= '0;
      done_sticky_q <= 1'b0;
      prdata_q      <= '0;
      mem_rd_q      <= 1'b0;
      mem_addr_q    <= '0;
      blend_go_q    <= 1'b0;
      blend_img_q   <= '0;
      blend_wm_q    <= '0;
      pixel_data_q  <= '0;
      new_pixel_q   <= 1'b0;
      image_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      img_rows_q    <= img_rows_d;
      img_cols_q    <= img_cols_d;
      wm_rows_q     <= wm_rows_d;
      wm_cols_q     <= wm_cols_d;
      wm_row_q      <= wm_row_d;
      wm_col_q      <= wm_col_d;
      r_q           <= r_d;
      c_q           <= c_d;
      img_idx_q     <= img_idx_d;
      wm_idx_q      <= wm_idx_d;
      pix_cnt_q     <= pix_cnt_d;
      done_sticky_q <= done_sticky_d;
      prdata_q      <= prdata_d;
      mem_rd_q      <= mem_rd_d;
      mem_addr_q    <= mem_addr_d;
      blend_go_q    <= blend_go_d;
      blend_img_q   <= blend_img_d;
      blend_wm_q    <= blend_wm_d;
      pixel_data_q  <= pixel_data_d;
      new_pixel_q   <= new_pixel_d;
      image_done_q  <= image_done_d;
    end
  end

  assign PRDATA     = prdata_q;
  assign mem_rd     = mem_rd_q;
  assign mem_addr   = mem_addr_q;
  assign blend_go   = blend_go_q;
  assign blend_img  = blend_img_q;
  assign blend_wm   = blend_wm_q;
  assign Pixel_Data = pixel_data_q;
  assign new_pixel  = new_pixel_q;
  assign Image_Done = image_done_q;

endmodule

// File: tb/tb_wm_pixel_sequencer.sv
// Bench for wm_pixel_sequencer: memory and blend responders, a pixel/address
// scoreboard fed from a reference raster model, and directed corner sequences.
`timescale 1ns/1ps
module tb_wm_pixel_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [19:0] PADDR = '0;
  logic [15:0] PWDATA = '0;
  logic [15:0] PRDATA;
  logic        mem_rd;
  logic [16:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        blend_go;
  logic [7:0]  blend_img, blend_wm;
  logic        blend_done;
  logic [7:0]  blend_res;
  logic [7:0]  Pixel_Data;
  logic        new_pixel, Image_Done;

  wm_pixel_sequencer #(.Data_Depth(8), .amba_word(16), .amba_addr_depth(20)) dut (
    .clk(clk), .rst(rst),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .blend_go(blend_go), .blend_img(blend_img), .blend_wm(blend_wm),
    .blend_done(blend_done), .blend_res(blend_res),
    .Pixel_Data(Pixel_Data), .new_pixel(new_pixel), .Image_Done(Image_Done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] img_dim;
    logic [15:0] wm_dim;
    logic [15:0] wm_pos;
    int          delay;
    bit          force_res;
    logic [7:0]  res_val;
    int          spacing;
    int          exp_px;
    int          exp_bl;
  } vec_t;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [7:0]  exp_pix_q[$];
  logic [16:0] exp_addr_q[$];
  bit          sb_en = 1'b0;
  int          cur_spacing = 0;
  int          epoch = 0;

  int np_cnt = 0, bg_cnt = 0, rd_cnt = 0, done_cnt = 0;
  int last_emit = -1, mon_epoch = 0;
  logic [7:0]  mon_pix;
  logic [16:0] mon_addr;

  int          bl_delay = 1;
  bit          bl_force = 1'b0;
  logic [7:0]  bl_val = '0;
  logic        bl_active;
  int          bl_cnt;

  function automatic logic [7:0] img_pix(input int i);
    return 8'((i * 7 + 3) & 255);
  endfunction

  function automatic logic [7:0] wm_pix(input int i);
    return 8'((i * 29 + 64) & 255);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    tests++;
    fails++;
    $display("FAIL %s: got 0x%0h with nothing expected", name, act);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_rd)
      mem_rdata <= mem_addr[16] ? wm_pix(int'(mem_addr[15:0])) : img_pix(int'(mem_addr[15:0]));
  end

  // Blend unit: answers delay cycles after blend_go (delay 0 = same cycle).
  always @(posedge clk) begin
    if (!rst) begin
      bl_active <= 1'b0;
      bl_cnt    <= 0;
    end else begin
      if (blend_go) begin
        bl_active <= 1'b1;
        bl_cnt    <= 1;
      end else if (bl_active) begin
        bl_cnt <= bl_cnt + 1;
      end
      if (blend_done) bl_active <= 1'b0;
    end
  end
  assign blend_done = (bl_delay == 0) ? blend_go : (bl_active && (bl_cnt == bl_delay));
  assign blend_res  = bl_force ? bl_val : (blend_img ^ blend_wm);

  always @(negedge clk) begin
    if (epoch != mon_epoch) begin
      mon_epoch = epoch;
      last_emit = -1;
    end
    if (rst) begin
      if (new_pixel) begin
        np_cnt++;
        if (sb_en) begin
          if (exp_pix_q.size() == 0) fail_now("pixel_extra", 32'(Pixel_Data));
          else begin
            mon_pix = exp_pix_q.pop_front();
            check("pixel_data", 32'(Pixel_Data), 32'(mon_pix));
          end
          if (cur_spacing != 0 && last_emit >= 0)
            check("pixel_spacing", 32'(cyc - last_emit), 32'(cur_spacing));
        end
        last_emit = cyc;
      end
      if (mem_rd) begin
        rd_cnt++;
        if (sb_en) begin
          if (exp_addr_q.size() == 0) fail_now("mem_addr_extra", 32'(mem_addr));
          else begin
            mon_addr = exp_addr_q.pop_front();
            check("mem_addr", 32'(mem_addr), 32'(mon_addr));
          end
        end
      end
      if (blend_go) bg_cnt++;
      if (Image_Done) begin
        done_cnt++;
        if (sb_en && last_emit >= 0) check("done_latency", 32'(cyc - last_emit), 32'd1);
      end
    end
  end

  task automatic apb_write(input int addr, input logic [15:0] data);
    @(negedge clk);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 20'(addr); PWDATA = data;
    @(negedge clk);
    PENABLE = 1'b1;
    @(negedge clk);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input int addr, output logic [15:0] data);
    @(negedge clk);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 20'(addr);
    @(negedge clk);
    PENABLE = 1'b1;
    data = PRDATA;
    @(negedge clk);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic build_expected(input vec_t v);
    int rows, cols, wr, wc, wrows, wcols, idx, w;
    logic [7:0] p;
    rows  = int'(v.img_dim[15:8]);
    cols  = int'(v.img_dim[7:0]);
    wrows = int'(v.wm_dim[15:8]);
    wcols = int'(v.wm_dim[7:0]);
    wr    = int'(v.wm_pos[15:8]);
    wc    = int'(v.wm_pos[7:0]);
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        idx = r * cols + c;
        exp_addr_q.push_back(17'(idx));
        p = img_pix(idx);
        if (r >= wr && r < wr + wrows && c >= wc && c < wc + wcols) begin
          w = (r - wr) * wcols + (c - wc);
          exp_addr_q.push_back(17'h10000 | 17'(w));
          p = v.force_res ? v.res_val : (p ^ wm_pix(w));
        end
        exp_pix_q.push_back(p);
      end
    end
  endtask

  task automatic wait_done(input string name, input int base_done, input int budget);
    int n;
    n = 0;
    while (done_cnt == base_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(done_cnt - base_done), 32'd1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[7];
    vec_t        busy_v;
    logic [15:0] rd;
    int          b_np, b_bg, b_rd, b_done, n;

    vecs[0] = '{16'h0202, 16'h0101, 16'h0101, 1, 1'b1, 8'h55, 0,  4, 1};
    vecs[1] = '{16'h0103, 16'h0202, 16'h0505, 1, 1'b0, 8'h00, 3,  3, 0};
    vecs[2] = '{16'h0000, 16'h0101, 16'h0000, 1, 1'b0, 8'h00, 0,  0, 0};
    vecs[3] = '{16'h0404, 16'h0303, 16'h0202, 2, 1'b0, 8'h00, 0, 16, 4};
    vecs[4] = '{16'h0202, 16'h0202, 16'h0000, 0, 1'b0, 8'h00, 6,  4, 4};
    vecs[5] = '{16'h0303, 16'hFFFF, 16'h0202, 1, 1'b0, 8'h00, 0,  9, 1};
    vecs[6] = '{16'h0500, 16'h0101, 16'h0000, 1, 1'b0, 8'h00, 0,  0, 0};
    busy_v  = '{16'h0104, 16'h0000, 16'h0000, 1, 1'b0, 8'h00, 3,  4, 0};

    repeat (3) @(negedge clk);
    check("rst_mem_rd",     32'(mem_rd), 32'd0);
    check("rst_mem_addr",   32'(mem_addr), 32'd0);
    check("rst_new_pixel",  32'(new_pixel), 32'd0);
    check("rst_image_done", 32'(Image_Done), 32'd0);
    check("rst_pixel_data", 32'(Pixel_Data), 32'd0);
    check("rst_prdata",     32'(PRDATA), 32'd0);
    rst = 1'b1;
    apb_read(4, rd); check("rst_status", 32'(rd), 32'd0);
    apb_read(1, rd); check("rst_img_dim", 32'(rd), 32'd0);

    for (int i = 0; i < 7; i++) begin
      epoch++;
      exp_pix_q.delete();
      exp_addr_q.delete();
      bl_delay = vecs[i].delay;
      bl_force = vecs[i].force_res;
      bl_val   = vecs[i].res_val;
      apb_write(1, vecs[i].img_dim);
      apb_write(2, vecs[i].wm_dim);
      apb_write(3, vecs[i].wm_pos);
      build_expected(vecs[i]);
      b_np = np_cnt; b_bg = bg_cnt; b_rd = rd_cnt; b_done = done_cnt;
      sb_en = 1'b1;
      cur_spacing = vecs[i].spacing;
      apb_write(0, 16'h0001);
      wait_done($sformatf("v%0d_done", i), b_done, 2000);
      repeat (3) @(negedge clk);
      sb_en = 1'b0;
      cur_spacing = 0;
      check($sformatf("v%0d_pixels", i), 32'(np_cnt - b_np), 32'(vecs[i].exp_px));
      check($sformatf("v%0d_blends", i), 32'(bg_cnt - b_bg), 32'(vecs[i].exp_bl));
      check($sformatf("v%0d_reads", i), 32'(rd_cnt - b_rd), 32'(vecs[i].exp_px + vecs[i].exp_bl));
      check($sformatf("v%0d_done_cnt", i), 32'(done_cnt - b_done), 32'd1);
      check($sformatf("v%0d_pix_left", i), 32'(exp_pix_q.size()), 32'd0);
      check($sformatf("v%0d_addr_left", i), 32'(exp_addr_q.size()), 32'd0);
      apb_read(5, rd); check($sformatf("v%0d_pix_cnt", i), 32'(rd), 32'(vecs[i].exp_px));
      apb_read(4, rd); check($sformatf("v%0d_status", i), 32'(rd), 32'h2);
    end

    // Dimension writes and a second start while busy are ignored.
    epoch++;
    exp_pix_q.delete();
    exp_addr_q.delete();
    bl_delay = 1; bl_force = 1'b0;
    apb_write(1, busy_v.img_dim);
    apb_write(2, busy_v.wm_dim);
    apb_write(3, busy_v.wm_pos);
    build_expected(busy_v);
    b_np = np_cnt; b_done = done_cnt;
    sb_en = 1'b1;
    cur_spacing = busy_v.spacing;
    apb_write(0, 16'h0001);
    apb_write(1, 16'h0808);
    apb_write(0, 16'h0001);
    wait_done("busy_done", b_done, 500);
    repeat (20) @(negedge clk);
    sb_en = 1'b0;
    cur_spacing = 0;
    check("busy_pixels", 32'(np_cnt - b_np), 32'd4);
    check("busy_done_cnt", 32'(done_cnt - b_done), 32'd1);
    apb_read(1, rd); check("busy_img_dim", 32'(rd), 32'h0104);
    apb_read(5, rd); check("busy_pix_cnt", 32'(rd), 32'd4);

    // Start and abort together act as abort; CTRL and unmapped offsets read 0.
    b_np = np_cnt; b_rd = rd_cnt;
    apb_write(0, 16'h0003);
    repeat (10) @(negedge clk);
    check("sa_pixels", 32'(np_cnt - b_np), 32'd0);
    check("sa_reads", 32'(rd_cnt - b_rd), 32'd0);
    apb_read(4, rd); check("sa_status", 32'(rd), 32'h2);
    apb_read(0, rd); check("ctrl_reads_zero", 32'(rd), 32'd0);
    apb_write(6, 16'hFFFF);
    apb_read(6, rd); check("unmapped_reads_zero", 32'(rd), 32'd0);

    // Abort while waiting in BLEND; the late blend_done must be ignored.
    bl_delay = 6; bl_force = 1'b0;
    apb_write(1, 16'h0101);
    apb_write(2, 16'h0101);
    apb_write(3, 16'h0000);
    b_np = np_cnt; b_bg = bg_cnt; b_done = done_cnt;
    apb_write(0, 16'h0001);
    n = 0;
    while (bg_cnt == b_bg && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("abort_blend_go", 32'(bg_cnt - b_bg), 32'd1);
    apb_write(0, 16'h0002);
    repeat (12) @(negedge clk);
    check("abort_pixels", 32'(np_cnt - b_np), 32'd0);
    check("abort_done", 32'(done_cnt - b_done), 32'd0);
    apb_read(4, rd); check("abort_status", 32'(rd), 32'h0);
    apb_read(5, rd); check("abort_pix_cnt", 32'(rd), 32'd0);

    // Reset in the middle of an image clears outputs at once and discards it.
    bl_delay = 1;
    apb_write(1, 16'h0808);
    apb_write(2, 16'h0202);
    apb_write(3, 16'h0303);
    b_np = np_cnt;
    apb_write(0, 16'h0001);
    apb_read(1, rd); check("mid_img_dim", 32'(rd), 32'h0808);
    n = 0;
    while (np_cnt - b_np < 3 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("mid_progress", 32'(np_cnt - b_np >= 3), 32'd1);
    n = 0;
    while (mem_rd !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    #2 rst = 1'b0;
    #1;
    check("mid_rst_mem_rd",     32'(mem_rd), 32'd0);
    check("mid_rst_mem_addr",   32'(mem_addr), 32'd0);
    check("mid_rst_pixel_data", 32'(Pixel_Data), 32'd0);
    check("mid_rst_new_pixel",  32'(new_pixel), 32'd0);
    check("mid_rst_blend_go",   32'(blend_go), 32'd0);
    check("mid_rst_blend_img",  32'(blend_img), 32'd0);
    check("mid_rst_blend_wm",   32'(blend_wm), 32'd0);
    check("mid_rst_prdata",     32'(PRDATA), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    b_np = np_cnt; b_done = done_cnt;
    repeat (30) @(negedge clk);
    check("post_rst_pixels", 32'(np_cnt - b_np), 32'd0);
    check("post_rst_done", 32'(done_cnt - b_done), 32'd0);
    apb_read(4, rd); check("post_rst_status", 32'(rd), 32'h0);
    apb_read(1, rd); check("post_rst_img_dim", 32'(rd), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wm_pixel_sequencer.md
WM_PIXEL_SEQUENCER -- requirements
Module: wm_pixel_sequencer

Interface
REQ-001 Parameters SHALL be: Data_Depth, default 8, pixel width; amba_word, default 16, APB data width; amba_addr_depth, default 20, APB address width.
REQ-002 Clock and reset SHALL be: clk  in  1  single clock; all flops on rising edge. rst  in  1  asynchronous, active-low.
REQ-003 APB ports SHALL be: PSEL, PENABLE, PWRITE  in  1 each  APB controls; PADDR  in  amba_addr_depth  word address; PWDATA  in  amba_word  write data; PRDATA  out  amba_word  read data.
REQ-004 mem_rd  out  1  pixel memory read strobe; mem_addr  out  17  bit16=1 selects watermark plane, [15:0] linear pixel index; mem_rdata  in  Data_Depth  read data.
REQ-005 blend_go  out  1  start pulse to blend datapath; blend_img, blend_wm  out  Data_Depth each  operands; blend_done  in  1  result valid; blend_res  in  Data_Depth  result.
REQ-006 Pixel_Data  out  Data_Depth  emitted pixel; new_pixel  out  1  Pixel_Data valid strobe; Image_Done  out  1  end-of-image pulse.

Function
REQ-007 APB SHALL be zero-wait: a write commits on PSEL&PENABLE&PWRITE; PRDATA SHALL be loaded on PSEL&!PENABLE&!PWRITE and held until the next read.
REQ-008 Registers (PADDR word offset) SHALL be: 0 CTRL (bit0 start, bit1 abort, both write-1 self-clearing, read 0); 1 IMG_DIM {rows[15:8],cols[7:0]}; 2 WM_DIM {rows,cols}; 3 WM_POS {row,col}; 4 STATUS RO {bit0 busy, bit1 done_sticky}; 5 PIX_CNT RO, pixels emitted since last start; other offsets read 0, writes ignored.
REQ-009 Writes to offsets 1-3 while busy SHALL be ignored; CTRL abort SHALL always be accepted.
REQ-010 FSM states SHALL be IDLE, REQ_IMG, WAIT_IMG, REQ_WM, WAIT_WM, BLEND, EMIT, DONE.
REQ-011 IDLE -> REQ_IMG on start write when rows!=0 and cols!=0; on start with rows==0 or cols==0, IDLE -> DONE directly.
REQ-012 REQ_IMG SHALL drive mem_rd=1, mem_addr={0,img_idx}; mem_rdata is valid the cycle after mem_rd and SHALL be captured in WAIT_IMG.
REQ-013 WAIT_IMG -> REQ_WM if wm_row<=r<wm_row+wm_rows and wm_col<=c<wm_col+wm_cols, else -> EMIT with Pixel_Data = image pixel.
REQ-014 REQ_WM SHALL drive mem_rd=1, mem_addr={1,wm_idx}; WAIT_WM captures the watermark pixel -> BLEND.
REQ-015 BLEND SHALL pulse blend_go for its first cycle only, hold blend_img/blend_wm stable, wait for blend_done, capture blend_res -> EMIT.
REQ-016 EMIT SHALL assert new_pixel for exactly 1 cycle with Pixel_Data valid that cycle, increment PIX_CNT, advance (r,c) in raster order; -> DONE after pixel (rows-1,cols-1), else -> REQ_IMG.
REQ-017 img_idx SHALL be a counter incremented by 1 per EMIT; wm_idx SHALL be incremented only on EMIT of a pixel inside the window; no multipliers.
REQ-018 Window parts beyond image edges SHALL be clipped; window coordinates are compared in 9-bit arithmetic so wm_row+wm_rows>255 does not wrap.
REQ-019 DONE SHALL pulse Image_Done for 1 cycle, set done_sticky -> IDLE; done_sticky clears on next start.
REQ-020 Abort SHALL force IDLE on the next edge from any state, suppress Image_Done and new_pixel, leave PIX_CNT unchanged; a blend_done arriving after abort SHALL be ignored.
REQ-021 Start while busy SHALL be ignored; start and abort in the same write SHALL act as abort.
REQ-022 Latency: non-window pixel exactly 3 cycles REQ_IMG->EMIT inclusive; window pixel 5 cycles plus BLEND cycles (min 6 with blend_done in first BLEND cycle).
REQ-023 busy SHALL be 1 in every state except IDLE.

Reset
REQ-024 rst low SHALL immediately force IDLE; all registers, counters, PRDATA, mem_rd, mem_addr, blend_go, blend_img, blend_wm, Pixel_Data, new_pixel, Image_Done to 0.
REQ-025 Reset mid-image SHALL discard the image; no Image_Done on release.

Verification
REQ-026 IMG_DIM=0x0202, WM_DIM=0x0101, WM_POS=0x0101, start, blend_done 1 cycle after blend_go with res 0x55 -> mem_addr 0x00000,0x00001,0x00002,0x00003,0x10000; 4 new_pixel; 4th Pixel_Data=0x55; one Image_Done; PIX_CNT=4.
REQ-027 IMG_DIM=0x0103, no overlap (WM_POS=0x0505) -> 3 new_pixel spaced 3 cycles, blend_go never asserted, Image_Done on cycle after 3rd EMIT.
REQ-028 IMG_DIM=0x0000, start -> Image_Done 1 cycle, new_pixel never, mem_rd never, STATUS=0x2.
REQ-029 IMG_DIM=0x0404, WM 3x3 at (2,2) -> 4 blends, wm_idx sequence 0,1,3,4 (clipped), Image_Done after 16 pixels.
REQ-030 Abort during BLEND, then blend_done -> IDLE, no new_pixel, no Image_Done, STATUS busy=0; rst low mid-image -> all outputs 0 within same cycle.
